// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ packet streams.
// Grant registered one cycle after valid; beats pass combinationally from registered grant, gated by wfull.
module fifo_wr_arbiter #(
  parameter  int NREQ        = 4,
  parameter  int DSIZE       = 8,
  parameter  int MAXBURST    = 8,
  parameter  int AWFULL_HOLD = 1,
  localparam int IDW         = $clog2(NREQ),
  localparam int CW          = $clog2(MAXBURST + 1)
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  input  logic                  awfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic [IDW-1:0]        grant_id,
  output logic                  burst_cut
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]  gid_q, gid_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cut_q, cut_d;

  logic            pick_vld;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  gid_inc;
  logic            busy, g_valid, g_last, beat, at_cap, rel, arb_ok;

  // Rotating search: first valid requester at rr_q, rr_q+1, ... wrapping at NREQ.
  always_comb begin
    logic [IDW:0] sum;
    sum      = '0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      if (!pick_vld && req_valid[sum[IDW-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = sum[IDW-1:0];
      end
    end
  end

  assign busy    = (state_q == BUSY);
  assign g_valid = req_valid[gid_q];
  assign g_last  = req_last[gid_q];
  assign beat    = busy && g_valid && !wfull;
  assign at_cap  = (cnt_q == CW'(MAXBURST - 1));
  assign rel     = beat && (g_last || at_cap);
  assign arb_ok  = !((AWFULL_HOLD != 0) && awfull);
  assign gid_inc = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);

  always_comb begin
    wdata = '0;
    if (busy) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gid_q == IDW'(i)) begin
          wdata = req_data[i*DSIZE +: DSIZE];
        end
      end
    end
  end

  assign req_ready = (busy && !wfull) ? grant_q : '0;
  assign winc      = beat;
  assign grant     = grant_q;
  assign grant_id  = gid_q;
  assign burst_cut = cut_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    cut_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld && arb_ok) begin
          state_d = BUSY;
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
          gid_d   = pick_id;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // The grant survives gaps in valid; only last or the burst cap ends it.
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = gid_inc;
          cnt_d   = '0;
          cut_d   = !g_last;
        end else if (beat) begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      cut_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      cut_q   <= cut_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table plus reset and burst-cap sequences,
// with a write-data scoreboard fed as stimulus is driven and drained on winc.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        wfull, awfull, winc, burst_cut;
  logic [7:0]  wdata;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAXBURST(8), .AWFULL_HOLD(1)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .wfull(wfull), .awfull(awfull),
    .winc(winc), .wdata(wdata), .grant(grant), .grant_id(grant_id), .burst_cut(burst_cut)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0]  v, l;
    logic [31:0] d;
    logic        wf, af;
    logic [3:0]  eg, er;
    logic        ew;
    logic [7:0]  ed;
    logic        ec;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                     input logic wf, input logic af, input logic [3:0] eg, input logic [3:0] er,
                     input logic ew, input logic [7:0] ed, input logic ec);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.wf = wf; t.af = af;
    t.eg = eg; t.er = er; t.ew = ew; t.ed = ed; t.ec = ec;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  // Scoreboard: every write strobe must match the next expected beat.
  always @(negedge wclk) begin
    if (wrst_n === 1'b1 && winc === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: unexpected write %0h", wdata);
      end else begin
        chk("sb_data", {24'h0, wdata}, {24'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_id;
    int r3_n, cyc, cuts;
    bit r0_done;

    // single packet from req1
    add(4'b0010, 4'b0000, 32'h0000A100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0010, 4'b0000, 32'h0000A100, 0, 0, 4'b0010, 4'b0010, 1, 8'hA1, 0);
    add(4'b0010, 4'b0000, 32'h0000A200, 0, 0, 4'b0010, 4'b0010, 1, 8'hA2, 0);
    add(4'b0010, 4'b0010, 32'h0000A300, 0, 0, 4'b0010, 4'b0010, 1, 8'hA3, 0);
    add(4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    // round-robin between req0 and req2, single-beat packets
    add(4'b0101, 4'b0101, 32'h00300010, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0101, 4'b0101, 32'h00300010, 0, 0, 4'b0100, 4'b0100, 1, 8'h30, 0);
    add(4'b0101, 4'b0101, 32'h00300010, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0101, 4'b0101, 32'h00300010, 0, 0, 4'b0001, 4'b0001, 1, 8'h10, 0);
    add(4'b0101, 4'b0101, 32'h00300010, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0101, 4'b0101, 32'h00300010, 0, 0, 4'b0100, 4'b0100, 1, 8'h30, 0);
    add(4'b0101, 4'b0101, 32'h00300010, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0101, 4'b0101, 32'h00300010, 0, 0, 4'b0001, 4'b0001, 1, 8'h10, 0);
    add(4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    // wfull backpressure mid-packet on req1
    add(4'b0010, 4'b0000, 32'h0000B100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0010, 4'b0000, 32'h0000B100, 0, 0, 4'b0010, 4'b0010, 1, 8'hB1, 0);
    for (int k = 0; k < 4; k++)
      add(4'b0010, 4'b0000, 32'h0000B200, 1, 0, 4'b0010, 4'b0000, 0, 8'hB2, 0);
    add(4'b0010, 4'b0000, 32'h0000B200, 0, 0, 4'b0010, 4'b0010, 1, 8'hB2, 0);
    add(4'b0010, 4'b0000, 32'h0000B300, 0, 0, 4'b0010, 4'b0010, 1, 8'hB3, 0);
    add(4'b0010, 4'b0010, 32'h0000B400, 0, 0, 4'b0010, 4'b0010, 1, 8'hB4, 0);
    add(4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    // awfull blocks new grants but not a grant in progress
    add(4'b0001, 4'b0000, 32'h000000C1, 0, 1, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0001, 4'b0000, 32'h000000C1, 0, 1, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0001, 4'b0000, 32'h000000C1, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0001, 4'b0000, 32'h000000C1, 0, 0, 4'b0001, 4'b0001, 1, 8'hC1, 0);
    add(4'b0001, 4'b0001, 32'h000000C2, 0, 1, 4'b0001, 4'b0001, 1, 8'hC2, 0);
    add(4'b0000, 4'b0000, 32'h00000000, 0, 1, 4'b0000, 4'b0000, 0, 8'h00, 0);
    add(4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0);

    req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0; awfull = 1'b0;
    wrst_n = 1'b1;
    #2 wrst_n = 1'b0;
    #10;
    chk("rst_grant", {28'h0, grant}, 0);
    chk("rst_gid", {30'h0, grant_id}, 0);
    chk("rst_winc", {31'h0, winc}, 0);
    chk("rst_ready", {28'h0, req_ready}, 0);
    chk("rst_cut", {31'h0, burst_cut}, 0);
    chk("rst_wdata", {24'h0, wdata}, 0);
    #5 wrst_n = 1'b1;

    exp_id = 2'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      step();
      req_valid = vecs[i].v; req_last = vecs[i].l; req_data = vecs[i].d;
      wfull = vecs[i].wf; awfull = vecs[i].af;
      if (vecs[i].ew) sb.push_back(vecs[i].ed);
      for (int b = 0; b < 4; b++)
        if (vecs[i].eg[b]) exp_id = 2'(b);
      @(negedge wclk);
      chk($sformatf("v%0d_grant", i), {28'h0, grant}, {28'h0, vecs[i].eg});
      chk($sformatf("v%0d_gid", i), {30'h0, grant_id}, {30'h0, exp_id});
      chk($sformatf("v%0d_ready", i), {28'h0, req_ready}, {28'h0, vecs[i].er});
      chk($sformatf("v%0d_winc", i), {31'h0, winc}, {31'h0, vecs[i].ew});
      chk($sformatf("v%0d_wdata", i), {24'h0, wdata}, {24'h0, vecs[i].ed});
      chk($sformatf("v%0d_cut", i), {31'h0, burst_cut}, {31'h0, vecs[i].ec});
    end

    // reset in the middle of a 5-beat packet from req2
    step(); req_valid = 4'b0100; req_last = 4'b0000; req_data = 32'h00D10000; awfull = 1'b0;
    @(negedge wclk); chk("rp_idle", {28'h0, grant}, 0);
    step(); sb.push_back(8'hD1);
    @(negedge wclk); chk("rp_grant2", {28'h0, grant}, 32'h4);
    step(); req_data = 32'h00D20000; sb.push_back(8'hD2);
    @(negedge wclk); chk("rp_beat2", {31'h0, winc}, 1);
    step(); req_data = 32'h00D30000;
    #2 wrst_n = 1'b0;
    #1;
    chk("rp_async_grant", {28'h0, grant}, 0);
    chk("rp_async_gid", {30'h0, grant_id}, 0);
    chk("rp_async_winc", {31'h0, winc}, 0);
    chk("rp_async_ready", {28'h0, req_ready}, 0);
    chk("rp_async_cut", {31'h0, burst_cut}, 0);
    @(posedge wclk); #3;
    req_valid = '0; wrst_n = 1'b1;
    step(); req_valid = 4'b0011; req_last = 4'b0011; req_data = 32'h00001B0A;
    @(negedge wclk); chk("rp_post_idle", {28'h0, grant}, 0);
    step(); sb.push_back(8'h0A);
    @(negedge wclk); chk("rp_rr_restart", {28'h0, grant}, 32'h1);
    step(); req_valid = 4'b0010;
    @(negedge wclk); chk("rp_gap", {28'h0, grant}, 0);
    step(); sb.push_back(8'h1B);
    @(negedge wclk); chk("rp_grant1", {28'h0, grant}, 32'h2);
    step(); req_valid = '0; req_last = '0;

    // burst cap: req3 streams 12 beats (last only on the 12th), req0 waits with one beat
    for (int k = 0; k < 8; k++) sb.push_back(8'(8'h40 + k));
    sb.push_back(8'h0F);
    for (int k = 8; k < 12; k++) sb.push_back(8'(8'h40 + k));
    r3_n = 0; r0_done = 1'b0; cyc = 0; cuts = 0;
    while ((r3_n < 12 || !r0_done) && cyc < 80) begin
      step();
      req_valid = {(r3_n < 12), 2'b00, !r0_done};
      req_last  = {(r3_n == 11), 2'b00, 1'b1};
      req_data  = {8'(8'h40 + r3_n), 16'h0000, 8'h0F};
      @(negedge wclk);
      if (burst_cut) begin
        cuts++;
        chk("cut_grant0", {28'h0, grant}, 0);
        chk("cut_after8", r3_n, 8);
      end
      if (req_valid[0] && req_ready[0]) begin
        r0_done = 1'b1;
        chk("r0_before_resume", r3_n, 8);
      end
      if (req_valid[3] && req_ready[3]) r3_n++;
      cyc++;
    end
    for (int k = 0; k < 3; k++) begin
      step(); req_valid = '0; req_last = '0;
      @(negedge wclk);
      if (burst_cut) cuts++;
    end
    chk("burst_no_timeout", {31'h0, (cyc < 80)}, 1);
    chk("burst_cut_count", cuts, 1);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
